edib_cmd_tx: RTL
================

// Module: edib_cmd_tx
// PURPOSE
// - Serial EDIB command/data transmitter; drives the CMDIn line of the EDIB receive stage.
// - Accepts one 16-bit word plus type per valid/ready handshake.
// - Serialises the word as one frame: gap, 6-bit sync, then 34 payload slots with complementary pairs and odd parity.
// - Sits between the APB register file (word source) and the EDIB serial pin.
// PARAMETERS
// BIT_CLKS   576  Clk cycles per line bit (matches receiver bit period of BpsNum+1)
// GAP_BITS   4    line bits of pre-frame gap before sync; 0 = no gap
// PORTS
// Clk      in   1   system clock
// Rst      in   1   synchronous reset, active-high
// TxValid  in   1   TxType/TxData valid
// TxReady  out  1   block can accept a word
// TxType   in   1   0 = command (sync 111000), 1 = data (sync 000111)
// TxData   in   16  word to send, MSB first
// CMDOut   out  1   serial line to receiver CMDIn
// Busy     out  1   frame in progress (any state except IDLE)
// TxDone   out  1   1-cycle pulse after last payload bit period ends
// BEHAVIOUR
// - Reset values: CMDOut=1, TxReady=0 during Rst then 1 in IDLE, Busy=0, TxDone=0; state returns to IDLE.
// - Rst mid-frame aborts the frame immediately; the word is lost and CMDOut=1 on the next cycle.
// - Accept: TxValid&&TxReady at a rising Clk edge.
//   - TxData/TxType are latched.
//   - TxReady drops the next cycle.
//   - The baud counter clears to 0.
// - Baud counter counts 0..BIT_CLKS-1. The slot advances when count==BIT_CLKS-1.
//   Every line bit lasts exactly BIT_CLKS cycles.
// - FSM, one-hot: IDLE -> GAP -> SYNC -> PAYLOAD -> DONE -> IDLE.
//   - IDLE: TxReady=1. CMDOut holds its last driven level.
//   - GAP: GAP_BITS bit periods. CMDOut=sync[5], i.e. 1 for cmd and 0 for data.
//     This keeps the receiver's 6-bit window from matching the wrong sync early.
//     If GAP_BITS=0, IDLE goes straight to SYNC.
//   - SYNC: 6 bit periods. CMDOut = SYNC_CMD/SYNC_DATA bits [5] down to [0].
//   - PAYLOAD: 34 slots, k=0..33, each driving line bit index i=33-k.
//     - Odd i (33..3) = TxData[(i-3)/2], so D15 goes first.
//     - i=1 = P, where P = ~^TxData; the 16 data bits plus P have odd weight.
//     - Even i = complement of the preceding odd bit, so each pair is (b,~b).
//   - DONE: 1 cycle, TxDone=1. CMDOut keeps ~P.
// - CMDOut is registered. It changes one cycle after the state/slot transition, never mid-bit.
// - Frame length is (GAP_BITS+6+34)*BIT_CLKS + 1 cycles from accept to TxDone (defaults: 25345).
// - Back-to-back: TxValid held high is accepted on the cycle after DONE (IDLE).
//   The minimum word spacing is therefore frame length + 1 cycle.
// - TxValid while Busy is ignored. TxData changes while Busy have no effect.
// - Width rules:
//   - Baud counter width is $clog2(BIT_CLKS). Slot counter is 6 bits, range 0..33. Gap counter width is $clog2(GAP_BITS+1).
//   - No wrap is visible outside a state; counters clear on every state entry.
// STRUCTURE
// - Package edib_pkg holds:
//   - SYNC_CMD=6'b111000 and SYNC_DATA=6'b000111;
//   - FRAME_SLOTS=34 and SYNC_BITS=6;
//   - the one-hot state constants IDLE/GAP/SYNC/PAYLOAD/DONE.
// - Sub-module edib_bit_tick: the baud counter. Inputs are Clk, Rst and clear; output is a tick on count==BIT_CLKS-1.
// - Payload shift: build a 34-bit frame vector at accept and shift it out MSB first.
// TESTING
// - Cmd 0xA5A5, GAP=4: line shows 1111 | 111000 | 10 01 10 01 01 10 01 10 (x2) | P=1 -> 10.
//   TxDone comes 25345 cycles after accept.
// - Data 0x0000: gap 0000, sync 000111, sixteen 01 pairs, P=1 -> 10.
// - Data 0x0001: P=0, last pairs 10 01. Bench loopback into the EDIB receiver gives Data=0x0001, Type=1, Error=0.
// - TxValid held high for 3 words: each is accepted exactly one cycle after TxDone. No word is dropped or duplicated, and TxReady=0 throughout each frame.
// - Rst=1 for one cycle during PAYLOAD slot 10: next cycle CMDOut=1, Busy=0, TxReady=1, and no TxDone pulse.
// - BIT_CLKS=8, GAP_BITS=0: every line transition is spaced by a multiple of 8 cycles. Accept to TxDone = 321 cycles.

Source files
------------

// File: rtl/edib_pkg.sv
// Shared constants and helpers for the EDIB command/data transmitter.
package edib_pkg;

    localparam int unsigned SYNC_BITS   = 6;
    localparam int unsigned FRAME_SLOTS = 34;
    localparam int unsigned DATA_W      = 16;

    localparam logic [SYNC_BITS-1:0] SYNC_CMD  = 6'b111000;
    localparam logic [SYNC_BITS-1:0] SYNC_DATA = 6'b000111;

    // One-hot frame states
    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        GAP     = 5'b00010,
        SYNC    = 5'b00100,
        PAYLOAD = 5'b01000,
        DONE    = 5'b10000
    } tx_state_t;

    // Payload line bits indexed 33..0: odd slots carry data (D15 first), slot 1 carries
    // odd parity, and every even slot is the complement of the odd slot above it.
    function automatic logic [FRAME_SLOTS-1:0] build_frame(input logic [DATA_W-1:0] data);
        logic [FRAME_SLOTS-1:0] frame;
        frame = '0;
        for (int k = 0; k < int'(DATA_W); k++) begin
            frame[2*k+3] = data[k];
            frame[2*k+2] = ~data[k];
        end
        frame[1] = ~^data;
        frame[0] = ^data;
        return frame;
    endfunction

endpackage

// File: rtl/edib_bit_tick.sv
// Baud counter: pulses Tick_c on the last clock of every line bit period.
module edib_bit_tick #(
    parameter int unsigned BIT_CLKS = 576
) (
    input  logic Clk,
    input  logic Rst,
    input  logic Clear,
    output logic Tick_c
);

    localparam int unsigned CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(BIT_CLKS - 1));
    assign Tick_c = w_last;

    // Count 0..BIT_CLKS-1, wrap on the last count, hold at zero while cleared
    always_ff @(posedge Clk) begin
        if (Rst || Clear) begin
            r_cnt <= '0;
        end else if (w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/edib_cmd_tx.sv
// EDIB serial command/data transmitter: one 16-bit word per frame of gap, sync and
// 34 complementary-pair payload slots, driven on CMDOut.
module edib_cmd_tx
    import edib_pkg::*;
#(
    parameter int unsigned BIT_CLKS = 576,
    parameter int unsigned GAP_BITS = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        TxValid,
    output logic        TxReady,
    input  logic        TxType,
    input  logic [15:0] TxData,
    output logic        CMDOut,
    output logic        Busy,
    output logic        TxDone
);

    localparam int unsigned GAP_W  = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
    localparam int unsigned SLOT_W = 6;

    tx_state_t              r_state;
    logic [SLOT_W-1:0]      r_slot;
    logic [GAP_W-1:0]       r_gap;
    logic [SYNC_BITS-1:0]   r_sync;
    logic [FRAME_SLOTS-1:0] r_shift;
    logic                   r_ready;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_cmd;

    logic                   w_tick;
    logic                   w_clear;
    logic                   w_accept;

    assign w_clear  = (r_state == IDLE);
    assign w_accept = TxValid && r_ready && (r_state == IDLE);

    assign TxReady = r_ready;
    assign Busy    = r_busy;
    assign TxDone  = r_done;
    assign CMDOut  = r_cmd;

    // Baud timing; held cleared in IDLE so the first bit starts at count 0 after accept
    edib_bit_tick #(
        .BIT_CLKS (BIT_CLKS)
    ) u_bit_tick (
        .Clk    (Clk),
        .Rst    (Rst),
        .Clear  (w_clear),
        .Tick_c (w_tick)
    );

    // Frame sequencer; CMDOut follows the current state/slot one cycle later
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= IDLE;
            r_slot  <= '0;
            r_gap   <= '0;
            r_sync  <= '0;
            r_shift <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cmd   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    if (w_accept) begin
                        r_sync  <= TxType ? SYNC_DATA : SYNC_CMD;
                        r_shift <= build_frame(TxData);
                        r_slot  <= '0;
                        r_gap   <= '0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= (GAP_BITS > 0) ? GAP : SYNC;
                    end
                end
                GAP: begin
                    // Idle level equal to the first sync bit keeps the receiver from an early match
                    r_cmd <= r_sync[SYNC_BITS-1];
                    if (w_tick) begin
                        if (r_gap == GAP_W'(GAP_BITS - 1)) begin
                            r_gap   <= '0;
                            r_state <= SYNC;
                        end else begin
                            r_gap <= r_gap + GAP_W'(1);
                        end
                    end
                end
                SYNC: begin
                    r_cmd <= r_sync[SYNC_BITS-1];
                    if (w_tick) begin
                        r_sync <= {r_sync[SYNC_BITS-2:0], 1'b0};
                        if (r_slot == SLOT_W'(SYNC_BITS - 1)) begin
                            r_slot  <= '0;
                            r_state <= PAYLOAD;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end
                end
                PAYLOAD: begin
                    r_cmd <= r_shift[FRAME_SLOTS-1];
                    if (w_tick) begin
                        r_shift <= {r_shift[FRAME_SLOTS-2:0], 1'b0};
                        if (r_slot == SLOT_W'(FRAME_SLOTS - 1)) begin
                            r_slot  <= '0;
                            r_state <= DONE;
                        end else begin
                            r_slot <= r_slot + SLOT_W'(1);
                        end
                    end
                end
                DONE: begin
                    // CMDOut holds ~P; ready rises together with the TxDone pulse
                    r_done  <= 1'b1;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
